chord_loader: RTL
=================

// Module: chord_loader
// PURPOSE
//  Producer side of the chord_module load interface: walks a song ROM, decodes note/rest/end words,
//  and drives note_in/duration_in/load_notes_phase/new_note/scheduler into chord_module. It assigns
//  each note to a free voice (1..3), gates playback between loads, and waits beats for rests.
//  Sits between the song ROM and chord_module, under the top-level play control.
// PARAMETERS
//  ADDR_W   7   song ROM address width; the song occupies 0 .. 2**ADDR_W-1
// PORTS
//  clk              in   1       system clock
//  reset            in   1       synchronous, active-low (0 = reset)
//  play             in   1       1 = run, 0 = pause (FSM frozen)
//  beat             in   1       1-cycle beat pulse
//  rom_addr         out  ADDR_W  song ROM address
//  rom_data         in   16      ROM word; valid 1 cycle after rom_addr changes
//  voice_busy       in   3       bit i = voice i+1 still sounding (from chord_module)
//  note_out         out  6       note to chord_module.note_in
//  duration_out     out  6       duration to chord_module.duration_in (beats)
//  load_notes_phase out  2       target voice 1..3 during a load; 0 otherwise
//  new_note         out  1       1-cycle load strobe
//  scheduler        out  1       1 = chord_module counts durations/plays; 0 during loads
//  song_done        out  1       level; end-of-song reached
// BEHAVIOUR
//  ROM word: [15]=rest, [14]=end, [13:12] ignored, [11:6]=note, [5:0]=duration.
//  Reset (reset==0 at posedge): state IDLE, rom_addr=0, note_out=0, duration_out=0,
//   load_notes_phase=0, new_note=0, scheduler=0, song_done=0, beat counter=0.
//  States: IDLE, FETCH, DECODE, LOAD, STALL, WAIT, DONE.
//   IDLE   : play=1 -> FETCH.
//   FETCH  : rom_addr stable one cycle -> DECODE.
//   DECODE : end=1 -> DONE (end has priority over rest). rest=1 -> WAIT with count=duration;
//            rest with duration 0 -> rom_addr+1, FETCH. note with duration 0 -> skipped (addr+1,
//            FETCH, no strobe). otherwise -> LOAD if a voice is free, else STALL.
//   LOAD   : one cycle: new_note=1, note_out/duration_out registered from word, load_notes_phase =
//            lowest free voice (bit0 -> 1, bit1 -> 2, bit2 -> 3), scheduler=0; rom_addr+1 -> FETCH.
//   STALL  : scheduler=1 until any voice_busy bit clears -> LOAD (voice re-evaluated that cycle).
//   WAIT   : scheduler=1; each beat decrements count; beat taken when count==1 -> addr+1, FETCH.
//   DONE   : song_done=1, scheduler=1 (lets notes ring out); play=0 -> IDLE, rom_addr=0, clears song_done.
//  Latency: ROM word to load strobe = 2 cycles (FETCH, DECODE) + LOAD; consecutive notes every 3 cycles.
//  scheduler=0 in IDLE/FETCH/DECODE/LOAD; 1 in STALL/WAIT/DONE.
//  new_note high for exactly one cycle per load; load_notes_phase nonzero only in that cycle.
//  Beat arriving in the same cycle as WAIT entry is not counted.
//  play=0 in any state but IDLE/DONE: hold all state, counters and rom_addr; new_note forced 0,
//   scheduler forced 0; resume exactly where paused when play returns to 1.
//  rom_addr at 2**ADDR_W-1 with no end word: increment wraps to 0 and behaves as end-of-song (DONE).
//  reset==0 in any state, including mid-LOAD: full reset values next edge; no partial strobe.
//  voice_busy is sampled; a voice freed and reloaded in the same cycle counts as free.
// CONFIGURATION
//  SONG_LOOP_EN defined: end word (or address wrap) -> rom_addr=0, FETCH; song_done pulses 1 cycle
//   per loop; DONE unreachable.
//  SONG_LOOP_EN undefined: behaviour above (DONE, song_done level until play=0).
// TESTING
//  1 ROM {note 23 d10, note 11 d10, note 7 d12, rest d10}, voice_busy=0 -> strobes with
//    phase 1,2,3 and notes 23,11,7 at 3-cycle spacing; scheduler=1 for exactly 10 beats.
//  2 voice_busy=3'b111 after three loads, 4th word note 50 d20 -> STALL, scheduler=1; clear
//    bit1 -> one strobe, phase=2, note_out=50, duration_out=20.
//  3 rest d0 then note 10 d0 then note 12 d5 -> no WAIT, no strobe for note 10, strobe for 12.
//  4 play=0 mid-WAIT with count=4, 6 beats applied -> count stays 4, scheduler=0; play=1 -> 4 more beats.
//  5 end word at addr 5 -> song_done=1, rom_addr held 5; play=0 -> IDLE, rom_addr=0, song_done=0;
//    with SONG_LOOP_EN -> 1-cycle song_done pulse, rom_addr=0, fetch restarts.
//  6 reset=0 during LOAD cycle -> next edge all outputs at reset values, new_note=0.

Source files
------------

// File: rtl/chord_loader.sv
// chord_loader: producer side of the chord_module load interface.
// Walks the song ROM, decodes note/rest/end words and loads each note into
// the lowest free voice (1..3), waiting on beats for rests.
// Build option: define SONG_LOOP_EN to restart the song from address 0 at
// its end (song_done then pulses once per loop) instead of stopping in DONE.
module chord_loader #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              beat,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic [2:0]        voice_busy,
    output logic [5:0]        note_out,
    output logic [5:0]        duration_out,
    output logic [1:0]        load_notes_phase,
    output logic              new_note,
    output logic              scheduler,
    output logic              song_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        LOAD,
        STALL,
        WAIT,
        DONE
    } state_t;

    state_t     state;
    logic [5:0] count;
    logic [5:0] pend_note;
    logic [5:0] pend_dur;
    logic [1:0] phase_q;
    logic       new_note_q;
    logic       scheduler_q;

    logic       w_rest;
    logic       w_end;
    logic [5:0] w_note;
    logic [5:0] w_dur;
    logic       unused_bits;
    logic [1:0] free_voice;
    logic       paused;
    logic       addr_last;
    logic       advance;

    assign w_rest      = rom_data[15];
    assign w_end       = rom_data[14];
    assign w_note      = rom_data[11:6];
    assign w_dur       = rom_data[5:0];
    assign unused_bits = ^rom_data[13:12];

    // Pausing freezes every state except IDLE and DONE, which react to play themselves.
    assign paused    = !play && (state != IDLE) && (state != DONE);
    assign addr_last = (rom_addr == {ADDR_W{1'b1}});

    // While paused the strobe, scheduler and voice number are masked, not lost.
    assign new_note         = new_note_q & ~paused;
    assign scheduler        = scheduler_q & ~paused;
    assign load_notes_phase = paused ? 2'd0 : phase_q;

    // Lowest numbered free voice, 0 when all three are still sounding.
    always_comb begin
        free_voice = 2'd0;
        if (!voice_busy[0])
            free_voice = 2'd1;
        else if (!voice_busy[1])
            free_voice = 2'd2;
        else if (!voice_busy[2])
            free_voice = 2'd3;
    end

    // Cycles that move on to the next ROM word: skipped zero-length words, the end of a load, the last rest beat.
    always_comb begin
        advance = 1'b0;
        case (state)
            DECODE:  advance = !w_end && (w_dur == 6'd0);
            LOAD:    advance = 1'b1;
            WAIT:    advance = beat && (count == 6'd1);
            default: advance = 1'b0;
        endcase
    end

    // Song walker FSM with registered load outputs; stepping past the last address counts as end of song.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            rom_addr     <= '0;
            note_out     <= 6'd0;
            duration_out <= 6'd0;
            phase_q      <= 2'd0;
            new_note_q   <= 1'b0;
            scheduler_q  <= 1'b0;
            song_done    <= 1'b0;
            count        <= 6'd0;
            pend_note    <= 6'd0;
            pend_dur     <= 6'd0;
        end else begin
`ifdef SONG_LOOP_EN
            song_done <= 1'b0;
`endif
            if (paused) begin
                state <= state;
            end else if (advance) begin
                new_note_q  <= 1'b0;
                phase_q     <= 2'd0;
                scheduler_q <= 1'b0;
                if (addr_last) begin
                    rom_addr  <= '0;
                    song_done <= 1'b1;
`ifdef SONG_LOOP_EN
                    state     <= FETCH;
`else
                    state       <= DONE;
                    scheduler_q <= 1'b1;
`endif
                end else begin
                    rom_addr <= rom_addr + 1'b1;
                    state    <= FETCH;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (play)
                            state <= FETCH;
                    end
                    FETCH: begin
                        state <= DECODE;
                    end
                    DECODE: begin
                        pend_note <= w_note;
                        pend_dur  <= w_dur;
                        if (w_end) begin
                            song_done <= 1'b1;
`ifdef SONG_LOOP_EN
                            rom_addr  <= '0;
                            state     <= FETCH;
`else
                            state       <= DONE;
                            scheduler_q <= 1'b1;
`endif
                        end else if (w_rest) begin
                            count       <= w_dur;
                            scheduler_q <= 1'b1;
                            state       <= WAIT;
                        end else if (free_voice != 2'd0) begin
                            new_note_q   <= 1'b1;
                            note_out     <= w_note;
                            duration_out <= w_dur;
                            phase_q      <= free_voice;
                            state        <= LOAD;
                        end else begin
                            scheduler_q <= 1'b1;
                            state       <= STALL;
                        end
                    end
                    STALL: begin
                        if (free_voice != 2'd0) begin
                            new_note_q   <= 1'b1;
                            note_out     <= pend_note;
                            duration_out <= pend_dur;
                            phase_q      <= free_voice;
                            scheduler_q  <= 1'b0;
                            state        <= LOAD;
                        end
                    end
                    WAIT: begin
                        if (beat)
                            count <= count - 1'b1;
                    end
                    DONE: begin
                        if (!play) begin
                            rom_addr    <= '0;
                            song_done   <= 1'b0;
                            scheduler_q <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
